// File: rtl/timer_ctrl.sv
// timer_ctrl: control FSM and shadow registers for a prescaled time base.
// Owns the auto-reload and prescale values (preload + active copies), raises
// an update event on counter wrap or cmd_reset, and sequences the time base
// through IDLE / RUN / CLEAR.
// Optional feature: define TIMER_CTRL_OPM_EN to honour the opm input
// (one-pulse mode). Without it opm is accepted but ignored.
module timer_ctrl #(
  parameter int BITS_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  cmd_start,
  input  logic                  cmd_stop,
  input  logic                  cmd_reset,
  input  logic                  opm,
  input  logic                  arpe,
  input  logic                  arr_we,
  input  logic [BITS_WIDTH-1:0] arr_wdata,
  input  logic                  psc_we,
  input  logic [BITS_WIDTH-1:0] psc_wdata,
  input  logic [BITS_WIDTH-1:0] tcnt,
  input  logic [BITS_WIDTH-1:0] nxt_tcnt,
  output logic                  tc_en,
  output logic                  tc_rst,
  output logic [BITS_WIDTH-1:0] tarr,
  output logic [BITS_WIDTH-1:0] tpsc,
  output logic                  uev,
  output logic                  uif,
  input  logic                  uif_clr,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    CLEAR = 2'b10
  } state_t;

  state_t                st;
  state_t                st_nxt;
  logic                  wrap;
  logic                  upd;
  logic                  opm_act;
  logic [BITS_WIDTH-1:0] arr_pre;
  logic [BITS_WIDTH-1:0] psc_pre;

  assign state = st;

`ifdef TIMER_CTRL_OPM_EN
  assign opm_act = opm;
`else
  logic unused_opm;
  assign unused_opm = opm;
  assign opm_act    = 1'b0;
`endif

  // Wrap detection and update-event condition
  always_comb begin
    wrap = tc_en & (tcnt == tarr) & (nxt_tcnt == '0);
    upd  = wrap | cmd_reset;
  end

  // Next-state decode; cmd_reset beats cmd_stop beats cmd_start
  always_comb begin
    st_nxt = st;
    if (cmd_reset) begin
      st_nxt = CLEAR;
    end else if (cmd_stop) begin
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE:    st_nxt = cmd_start ? RUN : IDLE;
        RUN:     st_nxt = (wrap && opm_act) ? CLEAR : RUN;
        CLEAR:   st_nxt = cmd_start ? RUN : IDLE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  // State register with time-base controls registered from the next state
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      st     <= IDLE;
      tc_en  <= 1'b0;
      tc_rst <= 1'b0;
    end else begin
      st     <= st_nxt;
      tc_en  <= (st_nxt == RUN);
      tc_rst <= (st_nxt == CLEAR);
    end
  end

  // Preload and active reload/prescale registers; same-cycle writes bypass
  // the preload so an update event picks up the new value immediately
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      arr_pre <= '1;
      psc_pre <= '0;
      tarr    <= '1;
      tpsc    <= '0;
    end else begin
      if (arr_we) arr_pre <= arr_wdata;
      if (psc_we) psc_pre <= psc_wdata;
      if (upd) begin
        tarr <= arr_we ? arr_wdata : arr_pre;
        tpsc <= psc_we ? psc_wdata : psc_pre;
      end else if (arr_we && !arpe) begin
        tarr <= arr_wdata;
      end
    end
  end

  // Registered update-event pulse
  always_ff @(posedge clk) begin
    if (!n_rst) uev <= 1'b0;
    else        uev <= upd;
  end

  // Sticky update flag; a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!n_rst)       uif <= 1'b0;
    else if (uev)     uif <= 1'b1;
    else if (uif_clr) uif <= 1'b0;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter: BITS_WIDTH, default 32, width of counter, reload and prescale values.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 n_rst  in  1  reset, synchronous, active-low.
REQ-004 cmd_start / cmd_stop / cmd_reset  in  1 each  single-cycle command pulses.
REQ-005 opm  in  1  one-pulse mode select; 1 = stop after first update event.
REQ-006 arpe  in  1  auto-reload preload enable; 1 = ARR writes buffered until update event.
REQ-007 arr_we, arr_wdata  in  1, BITS_WIDTH  reload-value write.
REQ-008 psc_we, psc_wdata  in  1, BITS_WIDTH  prescale-value write; always buffered.
REQ-009 tcnt, nxt_tcnt  in  BITS_WIDTH each  current/next count from time_base.
REQ-010 tc_en, tc_rst  out  1 each  enable and synchronous clear to time_base.
REQ-011 tarr, tpsc  out  BITS_WIDTH each  active reload and prescale values to time_base.
REQ-012 uev  out  1  one-cycle update-event pulse.
REQ-013 uif  out  1  sticky update flag; uif_clr  in  1  clears it.
REQ-014 state  out  2  FSM state: 00 IDLE, 01 RUN, 10 CLEAR.

Function
REQ-015 Preload registers arr_pre, psc_pre SHALL capture arr_wdata/psc_wdata on the edge where the matching _we is high.
REQ-016 With arpe=0, an arr write SHALL also update tarr on the same edge; with arpe=1 tarr SHALL change only on update.
REQ-017 Wrap SHALL be detected combinationally as tc_en & (tcnt==tarr) & (nxt_tcnt==0).
REQ-018 Update event SHALL be wrap OR cmd_reset; uev SHALL be high the cycle after that condition (registered).
REQ-019 On an update event edge, tarr<=arr_pre and tpsc<=psc_pre; a same-cycle write SHALL load the new wdata (write bypass).
REQ-020 uif SHALL set on every uev; uif_clr SHALL clear it; simultaneous set and clear SHALL leave uif=1.
REQ-021 IDLE: tc_en=0, tc_rst=0; cmd_start -> RUN next cycle. Counter value retained (pause).
REQ-022 RUN: tc_en=1, tc_rst=0; cmd_stop -> IDLE; wrap with opm=1 -> CLEAR.
REQ-023 CLEAR: tc_en=0, tc_rst=1 for exactly one cycle, then IDLE, or RUN if cmd_start arrives in CLEAR.
REQ-024 cmd_reset from any state SHALL go to CLEAR and force update event (REQ-018/019).
REQ-025 Command priority same cycle: cmd_reset > cmd_stop > cmd_start; wrap+cmd_stop in RUN SHALL still load shadows and pulse uev.
REQ-026 tc_en and tc_rst SHALL be registered, decoded from next state (no combinational path from commands to time_base).
REQ-027 tarr=0 SHALL be legal: wrap occurs every prescaled tick.

Reset
REQ-028 n_rst=0 at a rising edge SHALL set state=IDLE, tc_en=0, tc_rst=0, uev=0, uif=0.
REQ-029 Reset values: tarr=arr_pre='1 (all ones), tpsc=psc_pre=0.
REQ-030 Reset mid-RUN SHALL take priority over all commands and writes in that cycle.

Configuration
REQ-031 Macro TIMER_CTRL_OPM_EN: defined -> one-pulse mode per REQ-022/023.
REQ-032 Not defined -> opm port present but ignored; RUN leaves only on cmd_stop/cmd_reset; CLEAR entered only via cmd_reset.

Verification
REQ-033 Reset, then cmd_start, arr_pre=50, arpe=1, one cmd_reset -> tarr=50, uev one cycle, tcnt 0..50, uev one cycle after tcnt=50 & nxt_tcnt=0.
REQ-034 psc write 1 mid-RUN, tarr=50 -> tpsc stays 0 until wrap, then tcnt holds each value 2 cycles; uif=1 until uif_clr.
REQ-035 arpe=0, write arr=20 while tcnt=30 (tarr=50) -> tarr=20 next edge, counter runs to 50... per time_base compare rule, documented result checked.
REQ-036 opm=1 (TIMER_CTRL_OPM_EN), tarr=10 -> one wrap, state RUN->CLEAR->IDLE, tc_rst high one cycle, tcnt=0 held.
REQ-037 cmd_stop at tcnt=100 -> tc_en=0 next cycle, tcnt frozen at 100; cmd_start -> resumes at 101.
REQ-038 cmd_reset+cmd_stop+cmd_start same cycle -> CLEAR, uev pulse, then IDLE.
